// File: rtl/pipe_datapath_if.sv
// pipe_datapath_if: pre-decoded instruction bus into the pipelined datapath.
//   master: decode/control side, drives in_valid and the instruction fields,
//           samples in_ready.
//   slave : the datapath, samples the fields, drives in_ready.
//   Fields: ImmOp (sign-extended immediate), RegWrite, ALUctrl, ALUsrc,
//           rs1/rs2/rd, MemWrite, ResultSrc.
//   Transfer happens on a clock edge where in_valid & in_ready.
interface pipe_datapath_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int ALUctrl_WIDTH = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    ImmOp;
    logic                     RegWrite;
    logic [ALUctrl_WIDTH-1:0] ALUctrl;
    logic                     ALUsrc;
    logic [ADDRESS_WIDTH-1:0] rs1;
    logic [ADDRESS_WIDTH-1:0] rs2;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     MemWrite;
    logic                     ResultSrc;

    modport master (
        output in_valid, ImmOp, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd,
               MemWrite, ResultSrc,
        input  in_ready
    );

    modport slave (
        input  in_valid, ImmOp, RegWrite, ALUctrl, ALUsrc, rs1, rs2, rd,
               MemWrite, ResultSrc,
        output in_ready
    );
endinterface

// File: rtl/pipe_datapath.sv
// pipe_datapath: four-stage (ISS/EX/MEM/WB) pipelined datapath with register
// file, ALU and word-addressed data memory. RAW hazards are resolved by
// forwarding (MEM over WB) plus a one-cycle load-use stall at issue.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   bus         pipe_datapath_if.slave instruction handshake + fields
//   Zero        registered "EX ALU result == 0"
//   zero_valid  Zero belongs to a valid instruction
//   a0          register x10, read combinationally from the register file
//   stall_cnt   load-use stall cycles seen with in_valid=1
//
// Optional feature: define PIPE_DATAPATH_STALL_CNT_EN to build the saturating
// stall counter; otherwise stall_cnt is tied to 0.
module pipe_datapath #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = 5,
    parameter int ALUctrl_WIDTH   = 3,
    parameter int DMEM_ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_datapath_if.slave        bus,
    output logic                  Zero,
    output logic                  zero_valid,
    output logic [DATA_WIDTH-1:0] a0,
    output logic [31:0]           stall_cnt
);
    localparam int NREG  = 2**ADDRESS_WIDTH;
    localparam int NWORD = 2**DMEM_ADDR_WIDTH;
    localparam int SHW   = $clog2(DATA_WIDTH);

    localparam logic [ALUctrl_WIDTH-1:0] ALU_ADD = 0;
    localparam logic [ALUctrl_WIDTH-1:0] ALU_SUB = 1;
    localparam logic [ALUctrl_WIDTH-1:0] ALU_AND = 2;
    localparam logic [ALUctrl_WIDTH-1:0] ALU_OR  = 3;
    localparam logic [ALUctrl_WIDTH-1:0] ALU_XOR = 4;
    localparam logic [ALUctrl_WIDTH-1:0] ALU_SLT = 5;
    localparam logic [ALUctrl_WIDTH-1:0] ALU_SLL = 6;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    imm;
        logic [DATA_WIDTH-1:0]    op1;   // rs1 data read at issue
        logic [DATA_WIDTH-1:0]    op2;   // rs2 data read at issue
        logic [ALUctrl_WIDTH-1:0] ctrl;
        logic                     alusrc;
        logic                     rw;
        logic                     mw;
        logic                     rsrc;
        logic [ADDRESS_WIDTH-1:0] rs1;
        logic [ADDRESS_WIDTH-1:0] rs2;
        logic [ADDRESS_WIDTH-1:0] rd;
    } ex_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    alu;
        logic [DATA_WIDTH-1:0]    sd;    // store data (forwarded rs2)
        logic                     rw;
        logic                     mw;
        logic                     rsrc;
        logic [ADDRESS_WIDTH-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    res;
        logic                     rw;
        logic [ADDRESS_WIDTH-1:0] rd;
    } wb_t;

    // Stage valids: [0]=EX, [1]=MEM, [2]=WB
    logic [2:0]            vld_pipe_q;
    ex_t                   ex_q, ex_d;
    mem_t                  mem_q, mem_d;
    wb_t                   wb_q, wb_d;
    logic                  zero_q, zero_valid_q;
    logic [DATA_WIDTH-1:0] rf_q [NREG];
    logic [DATA_WIDTH-1:0] dmem [NWORD];

    logic                  accept, hazard, ld_in_ex, use_rs2, wb_we;
    logic                  fwd_mem_ok, fwd_wb_ok;
    logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd, alu_b, alu_res, ld_data;
    logic [DMEM_ADDR_WIDTH-1:0] mem_addr;

    // ---------------- Issue ----------------
    // Load in EX whose rd is needed by the incoming instruction: hold it one
    // cycle so the load data can be picked up from WB.
    assign ld_in_ex = vld_pipe_q[0] & ex_q.rsrc & ex_q.rw & (ex_q.rd != '0);
    assign use_rs2  = ~bus.ALUsrc | bus.MemWrite;
    assign hazard   = ld_in_ex & ((bus.rs1 == ex_q.rd) |
                                  (use_rs2 & (bus.rs2 == ex_q.rd)));
    assign bus.in_ready = rst | ~hazard;
    assign accept       = bus.in_valid & bus.in_ready;

    assign wb_we = vld_pipe_q[2] & wb_q.rw & (wb_q.rd != '0);

    always_comb begin
        ex_d        = '0;
        ex_d.imm    = bus.ImmOp;
        ex_d.ctrl   = bus.ALUctrl;
        ex_d.alusrc = bus.ALUsrc;
        ex_d.rw     = bus.RegWrite;
        ex_d.mw     = bus.MemWrite;
        ex_d.rsrc   = bus.ResultSrc;
        ex_d.rs1    = bus.rs1;
        ex_d.rs2    = bus.rs2;
        ex_d.rd     = bus.rd;
        // Register file read with write-through of the WB write this cycle
        ex_d.op1    = (wb_we && wb_q.rd == bus.rs1) ? wb_q.res : rf_q[bus.rs1];
        ex_d.op2    = (wb_we && wb_q.rd == bus.rs2) ? wb_q.res : rf_q[bus.rs2];
    end

    // ---------------- Execute ----------------
    // A load sitting in MEM has no data yet; the issue stall guarantees no
    // consumer of it needs MEM forwarding.
    assign fwd_mem_ok = vld_pipe_q[1] & mem_q.rw & (mem_q.rd != '0) & ~mem_q.rsrc;
    assign fwd_wb_ok  = wb_we;

    always_comb begin
        rs1_fwd = ex_q.op1;
        if (fwd_mem_ok && mem_q.rd == ex_q.rs1)     rs1_fwd = mem_q.alu;
        else if (fwd_wb_ok && wb_q.rd == ex_q.rs1)  rs1_fwd = wb_q.res;
        rs2_fwd = ex_q.op2;
        if (fwd_mem_ok && mem_q.rd == ex_q.rs2)     rs2_fwd = mem_q.alu;
        else if (fwd_wb_ok && wb_q.rd == ex_q.rs2)  rs2_fwd = wb_q.res;
    end

    assign alu_b = ex_q.alusrc ? ex_q.imm : rs2_fwd;

    always_comb begin
        alu_res = '0;
        case (ex_q.ctrl)
            ALU_ADD: alu_res = rs1_fwd + alu_b;
            ALU_SUB: alu_res = rs1_fwd - alu_b;
            ALU_AND: alu_res = rs1_fwd & alu_b;
            ALU_OR:  alu_res = rs1_fwd | alu_b;
            ALU_XOR: alu_res = rs1_fwd ^ alu_b;
            ALU_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}},
                                ($signed(rs1_fwd) < $signed(alu_b))};
            ALU_SLL: alu_res = rs1_fwd << alu_b[SHW-1:0];
            default: alu_res = rs1_fwd >> alu_b[SHW-1:0];
        endcase
    end

    always_comb begin
        mem_d      = '0;
        mem_d.alu  = alu_res;
        mem_d.sd   = rs2_fwd;
        mem_d.rw   = ex_q.rw;
        mem_d.mw   = ex_q.mw;
        mem_d.rsrc = ex_q.rsrc;
        mem_d.rd   = ex_q.rd;
    end

    // ---------------- Memory ----------------
    // Byte address -> word index; upper bits dropped so addresses wrap.
    assign mem_addr = mem_q.alu[DMEM_ADDR_WIDTH+1:2];
    assign ld_data  = dmem[mem_addr];

    always_comb begin
        wb_d     = '0;
        wb_d.res = mem_q.rsrc ? ld_data : mem_q.alu;
        wb_d.rw  = mem_q.rw;
        wb_d.rd  = mem_q.rd;
    end

    // Memory contents survive reset; a store in MEM during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && vld_pipe_q[1] && mem_q.mw)
            dmem[mem_addr] <= mem_q.sd;
    end

    // ---------------- Pipeline control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q   <= '0;
            zero_q       <= 1'b0;
            zero_valid_q <= 1'b0;
        end else begin
            vld_pipe_q   <= {vld_pipe_q[1:0], accept};  // stall pushes a bubble
            zero_valid_q <= vld_pipe_q[0];
            zero_q       <= vld_pipe_q[0] && (alu_res == '0);
        end
    end

    // Datapath payload is qualified by vld_pipe_q and needs no reset.
    always_ff @(posedge clk) begin
        ex_q  <= ex_d;
        mem_q <= mem_d;
        wb_q  <= wb_d;
    end

    // ---------------- Write back / register file ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_we) begin
            rf_q[wb_q.rd] <= wb_q.res;
        end
    end

    assign a0         = rf_q[10];
    assign Zero       = zero_q;
    assign zero_valid = zero_valid_q;

`ifdef PIPE_DATAPATH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (bus.in_valid && !bus.in_ready && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_datapath.sv
// Testbench for pipe_datapath: sequential ISA reference model + scoreboard.
// Each accepted instruction is executed on the model; the expected Zero and
// post-writeback a0 are queued and a monitor checks them when zero_valid fires.
module tb_pipe_datapath;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 3;
    localparam int MAW = 8;
    localparam int NW  = 2**MAW;
`ifdef PIPE_DATAPATH_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  ctrl;
        logic        alusrc, rw, mw, rsrc;
        logic [4:0]  rs1, rs2, rd;
    } instr_t;

    typedef struct { logic zero; logic [31:0] a0; } exp_t;
    typedef struct { int due; logic [31:0] a0; } a0chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic Zero, zero_valid;
    logic [DW-1:0] a0;
    logic [31:0] stall_cnt;

    pipe_datapath_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALUctrl_WIDTH(CW)) bus();

    pipe_datapath #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALUctrl_WIDTH(CW),
                    .DMEM_ADDR_WIDTH(MAW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .Zero(Zero), .zero_valid(zero_valid), .a0(a0), .stall_cnt(stall_cnt));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [31:0] mregs [32];
    logic [31:0] mmem  [NW];
    exp_t   sbq[$];
    a0chk_t a0q[$];
    int     exp_stalls = 0;
    instr_t prev;
    bit     prev_valid = 0;
    int     last_acc = -10;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic instr_t mk(input logic [2:0] c, input logic [4:0] rd, rs1, rs2,
                                  input logic [31:0] imm, input logic alusrc, rw, mw, rsrc);
        instr_t i;
        i.ctrl = c; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
        i.alusrc = alusrc; i.rw = rw; i.mw = mw; i.rsrc = rsrc;
        return i;
    endfunction
    function automatic instr_t alu_rr(input logic [2:0] c, input logic [4:0] rd, rs1, rs2);
        return mk(c, rd, rs1, rs2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic instr_t alu_ri(input logic [2:0] c, input logic [4:0] rd, rs1, input logic [31:0] imm);
        return mk(c, rd, rs1, 5'd0, imm, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic instr_t sw(input logic [4:0] rs2, rs1, input logic [31:0] imm);
        return mk(3'd0, 5'd0, rs1, rs2, imm, 1'b1, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic instr_t lw(input logic [4:0] rd, rs1, input logic [31:0] imm);
        return mk(3'd0, rd, rs1, 5'd0, imm, 1'b1, 1'b1, 1'b0, 1'b1);
    endfunction

    // Architectural (one instruction at a time) execution.
    function automatic exp_t model_exec(input instr_t i);
        logic [31:0] a, b, r, ld;
        int wa;
        exp_t e;
        a = mregs[i.rs1];
        b = i.alusrc ? i.imm : mregs[i.rs2];
        case (i.ctrl)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: r = a << (b % 32);
            default: r = a >> (b % 32);
        endcase
        wa = int'((r / 4) % NW);
        ld = mmem[wa];
        if (i.mw) mmem[wa] = mregs[i.rs2];
        if (i.rw && i.rd != 0) mregs[i.rd] = i.rsrc ? ld : r;
        e.zero = (r == 32'd0);
        e.a0   = mregs[10];
        return e;
    endfunction

    function automatic bit load_use(input instr_t p, input instr_t i);
        if (!(p.rsrc && p.rw && p.rd != 0)) return 0;
        return (i.rs1 == p.rd) || ((!i.alusrc || i.mw) && i.rs2 == p.rd);
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
        sbq.delete();
        a0q.delete();
        exp_stalls = 0;
        prev_valid = 0;
        last_acc = -10;
    endfunction

    task automatic drive(input instr_t i);
        bus.ImmOp = i.imm; bus.RegWrite = i.rw; bus.ALUctrl = i.ctrl;
        bus.ALUsrc = i.alusrc; bus.rs1 = i.rs1; bus.rs2 = i.rs2; bus.rd = i.rd;
        bus.MemWrite = i.mw; bus.ResultSrc = i.rsrc;
    endtask

    // Present one instruction, wait for acceptance, check stall length.
    task automatic issue(input instr_t ins);
        int st;
        bit hz;
        exp_t e;
        drive(ins);
        bus.in_valid = 1'b1;
        @(negedge clk);
        hz = prev_valid && (cyc == last_acc + 1) && load_use(prev, ins);
        st = 0;
        while (!bus.in_ready && st < 4) begin
            st++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            $display("FAIL issue_timeout: in_ready stuck at 0 (cycle %0d)", cyc);
            $fatal(1, "issue timeout");
        end
        chk("stall_len", st, hz ? 32'd1 : 32'd0);
        if (hz) exp_stalls++;
        e = model_exec(ins);
        sbq.push_back(e);
        prev = ins;
        prev_valid = 1;
        last_acc = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || a0q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (n < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_a0"}, a0, 32'd0);
        chk({tag, "_zero_valid"}, zero_valid, 32'd0);
        chk({tag, "_Zero"}, Zero, 32'd0);
        chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        drive(alu_ri(3'd0, 5'd10, 5'd0, 32'd99));
        bus.in_valid = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            chk("rst_in_ready", bus.in_ready, 32'd1);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        clear_model();
        check_idle_outputs("after_rst");
    endtask

    // Every register reads back 0 (via Zero and a0 of add x10,xk,x0).
    task automatic reg_sweep();
        for (int k = 1; k < 32; k++) issue(alu_rr(3'd0, 5'd10, 5'(k), 5'd0));
        drain();
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        a0chk_t c;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (zero_valid) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_zero_valid", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("zero", Zero, e.zero);
                        c.due = cyc + 2;
                        c.a0 = e.a0;
                        a0q.push_back(c);
                    end
                end
                if (a0q.size() != 0 && a0q[0].due == cyc) begin
                    c = a0q.pop_front();
                    chk("a0", a0, c.a0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t r;
        int pool [6] = '{0, 1, 2, 3, 10, 11};
        bus.in_valid = 1'b0;
        drive(mk(3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // 1: reset with in_valid held high, then every register is 0
        do_reset(2);
        reg_sweep();

        // Give every memory word a known value
        for (int w = 0; w < NW; w++) begin
            issue(alu_ri(3'd0, 5'd1, 5'd0, $urandom | 32'h100));
            issue(sw(5'd1, 5'd0, 32'(w * 4)));
        end
        drain();

        // 2: ALU chain with back-to-back dependency
        issue(alu_ri(3'd0, 5'd10, 5'd0, 32'd5));
        issue(alu_rr(3'd0, 5'd10, 5'd10, 5'd10));
        drain();

        // 3: store, load, load-use consumer (one stall)
        issue(sw(5'd10, 5'd0, 32'd4));
        issue(lw(5'd11, 5'd0, 32'd4));
        issue(alu_rr(3'd0, 5'd10, 5'd11, 5'd11));
        drain();
        @(negedge clk);
        chk("stall_cnt_t3", stall_cnt, CNT_EN ? 32'(exp_stalls) : 32'd0);
        @(posedge clk); #1;

        // 4: Zero flag
        issue(alu_ri(3'd0, 5'd10, 5'd0, 32'd10));
        issue(alu_rr(3'd1, 5'd5, 5'd10, 5'd10));
        issue(alu_ri(3'd1, 5'd5, 5'd10, 32'd3));
        drain();

        // 5: x0 discards writes; store address wraps onto word 0
        issue(alu_ri(3'd0, 5'd0, 5'd0, 32'd7));
        issue(alu_rr(3'd0, 5'd10, 5'd0, 5'd0));
        issue(alu_ri(3'd0, 5'd12, 5'd0, 32'h1234));
        issue(sw(5'd12, 5'd0, 32'(4 * NW)));
        issue(lw(5'd10, 5'd0, 32'd0));
        drain();

        // Randomised traffic with a small register pool to force hazards
        for (int n = 0; n < 400; n++) begin
            r.rd     = 5'(pool[$urandom_range(0, 5)]);
            r.rs1    = 5'(pool[$urandom_range(0, 5)]);
            r.rs2    = 5'(pool[$urandom_range(0, 5)]);
            r.ctrl   = 3'($urandom_range(0, 7));
            r.alusrc = 1'($urandom_range(0, 1));
            r.imm    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            r.rsrc   = ($urandom_range(0, 3) == 0);
            r.mw     = ($urandom_range(0, 4) == 0);
            r.rw     = ($urandom_range(0, 4) != 0);
            issue(r);
            if ($urandom_range(0, 4) == 0) idle();
        end
        drain();
        @(negedge clk);
        chk("stall_cnt_rand", stall_cnt, CNT_EN ? 32'(exp_stalls) : 32'd0);
        @(posedge clk); #1;

        // 6: reset while a store is in EX drops the store
        issue(alu_ri(3'd0, 5'd10, 5'd0, 32'h55));
        drain();
        drive(sw(5'd10, 5'd0, 32'd8));
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("t6_ready", bus.in_ready, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        check_idle_outputs("t6");
        reg_sweep();
        issue(lw(5'd10, 5'd0, 32'd8));
        drain();

        // Short random run after the mid-flight reset
        for (int n = 0; n < 100; n++) begin
            r.rd     = 5'(pool[$urandom_range(0, 5)]);
            r.rs1    = 5'(pool[$urandom_range(0, 5)]);
            r.rs2    = 5'(pool[$urandom_range(0, 5)]);
            r.ctrl   = 3'($urandom_range(0, 7));
            r.alusrc = 1'($urandom_range(0, 1));
            r.imm    = 32'($urandom_range(0, 1023));
            r.rsrc   = ($urandom_range(0, 2) == 0);
            r.mw     = ($urandom_range(0, 4) == 0);
            r.rw     = 1'b1;
            issue(r);
        end
        drain();
        @(negedge clk);
        chk("stall_cnt_end", stall_cnt, CNT_EN ? 32'(exp_stalls) : 32'd0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_datapath.md
Name: pipe_datapath

Overview:
Four-stage pipelined successor to the single-cycle reduced datapath: issue (ISS), execute (EX), memory (MEM) and writeback (WB).
- Accepts one pre-decoded instruction per cycle over a valid/ready handshake.
- Contains the register file, ALU and data memory.
- Resolves RAW hazards by forwarding, plus a one-cycle load-use stall.
- Sits between the decode/control unit and the top level; exposes a0 and a registered Zero flag for branch resolution.

Parameters:
- DATA_WIDTH, 32, datapath and register width.
- ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH registers).
- ALUctrl_WIDTH, 3, ALU opcode width.
- DMEM_ADDR_WIDTH, 8, data memory word-address width (2**DMEM_ADDR_WIDTH words).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction fields below are valid.
- in_ready  out  1  block accepts the instruction this cycle.
- ImmOp  in  DATA_WIDTH  sign-extended immediate.
- RegWrite  in  1  instruction writes rd.
- ALUctrl  in  ALUctrl_WIDTH  ALU operation.
- ALUsrc  in  1  1 selects ImmOp as operand 2; 0 selects rs2 data.
- rs1, rs2, rd  in  ADDRESS_WIDTH  register indices.
- MemWrite  in  1  store regOp2 to memory.
- ResultSrc  in  1  1 writes load data back; 0 writes ALU result.
- Zero  out  1  registered: EX-stage ALU result == 0.
- zero_valid  out  1  Zero corresponds to a valid instruction.
- a0  out  DATA_WIDTH  architectural value of register 10.
- stall_cnt  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset:
  - Clears all stage valid bits; in-flight instructions are dropped, including their stores.
  - Clears every register-file entry to 0.
  - Data memory is not cleared.
  - Output reset values: Zero=0, zero_valid=0, a0=0, stall_cnt=0. in_ready is combinational and reads 1 during reset.
- Accept: on in_valid & in_ready the fields are latched into the ISS→EX register.
  - Operands are read from the register file at issue.
  - The register file bypasses same-cycle writes: if the WB write index equals the read index and is non-zero, the read returns the WB data.
- EX: ALU operand 1 = rs1 data; operand 2 = ALUsrc ? ImmOp : rs2 data. Both are forwarded as below.
  - ALUctrl encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed, result 0/1 zero-extended), 110 sll, 111 srl.
  - Shift amount = low $clog2(DATA_WIDTH) bits of operand 2. Add/sub wrap modulo 2**DATA_WIDTH.
  - Zero and zero_valid are registered from EX, so they are visible the cycle after the instruction leaves EX.
- Forwarding, priority MEM over WB, only when the producer has RegWrite=1 and rd≠0:
  - MEM producer with ResultSrc=0: forward its ALU result.
  - WB producer: forward its result (ALU result or load data).
- MEM:
  - Word address = ALUout[DMEM_ADDR_WIDTH+1:2]; upper bits ignored, so addresses wrap.
  - Load read is combinational; the value is latched into WB.
  - Store writes regOp2 (forwarded value) at the end of the MEM cycle.
- WB: writes the result to rd at the clock edge if RegWrite and rd≠0. Writes to x0 are discarded; x0 always reads 0.
- Load-use stall: in_ready=0 when the instruction in ISS→EX is a load (ResultSrc=1, RegWrite=1, rd≠0) and the incoming rs1 or rs2 equals its rd. rs2 counts only if ALUsrc=0 or MemWrite=1.
  - The stall lasts exactly one cycle: a bubble (valid=0) enters EX, and downstream stages keep advancing.
  - If in_valid=0, in_ready still reflects the hazard but no stall is counted.
- Latency: an instruction accepted at cycle N writes the register file at the end of cycle N+3. A dependent instruction can issue at N+1 with no stall (ALU producer) or at N+2 (load producer).
- Back-to-back store then load to the same address: the load in MEM one cycle later reads the new data.
- a0 reflects the register file combinationally, so it updates the cycle after the WB write edge.

Optional Feature:
- Macro: PIPE_DATAPATH_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on every cycle with in_valid=1 and in_ready=0. It saturates at 2**32-1 and is cleared by rst.
- Not defined: stall_cnt is tied to 0 and no counter logic is synthesised. The port remains present.

Test Plan:
1. Reset then idle: assert rst for 2 cycles with in_valid=1 → a0=0, zero_valid=0, in_ready=1, no register writes.
2. ALU chain: addi x10,x0,5; then add x10,x10,x10 next cycle → no stall; a0=5 after the first WB, then a0=10 one cycle later.
3. Load-use: sw x10(=10) to addr 0x4; lw x11,4(x0); add x10,x11,x11 → in_ready=0 for exactly 1 cycle; a0=20; stall_cnt=1 if the macro is enabled.
4. Zero flag: sub x5,x10,x10 with x10=10 → Zero=1, zero_valid=1 one cycle after EX. With x5=x10−ImmOp(3) → Zero=0.
5. x0 and wrap: addi x0,x0,7 then add x10,x0,x0 → a0=0. Store to byte address 4·2**DMEM_ADDR_WIDTH aliases word 0; a load from addr 0 returns the stored value.
6. Reset mid-flight: issue a store to addr 8 with value 0x55, assert rst while it is in EX → memory word at addr 8 unchanged; all registers 0.
